// File: rtl/decode_pipe_stage_if.sv
// Fetch, writeback and execute-side signals of decode_pipe_stage.
// The slave modport is the stage itself; master is whoever drives fetch and execute.
interface decode_pipe_stage_if #(
  parameter int DATA_W = 16,
  parameter int RID_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       instruction;
  logic [DATA_W-1:0] pc_plus_two;
  logic              wb_en;
  logic [RID_W-1:0]  wb_id;
  logic [DATA_W-1:0] wb_value;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_rs_value;
  logic [DATA_W-1:0] out_rt_value;
  logic [DATA_W-1:0] out_imm;
  logic [DATA_W-1:0] out_pc_plus_two;
  logic [RID_W-1:0]  out_rs_id;
  logic [RID_W-1:0]  out_rt_id;
  logic [RID_W-1:0]  out_rd_id;
  logic [3:0]        out_opcode;
  logic              out_is_load;
  logic [15:0]       stall_cycles;

  modport slave (
    input  in_valid, instruction, pc_plus_two, wb_en, wb_id, wb_value, flush, out_ready,
    output in_ready, out_valid, out_rs_value, out_rt_value, out_imm, out_pc_plus_two,
           out_rs_id, out_rt_id, out_rd_id, out_opcode, out_is_load, stall_cycles
  );

  modport master (
    output in_valid, instruction, pc_plus_two, wb_en, wb_id, wb_value, flush, out_ready,
    input  in_ready, out_valid, out_rs_value, out_rt_value, out_imm, out_pc_plus_two,
           out_rs_id, out_rt_id, out_rd_id, out_opcode, out_is_load, stall_cycles
  );
endinterface

// File: rtl/decode_pipe_stage.sv
// Decode stage: register-file read, load-use interlock, one-entry output register with hold.
// Define DECODE_WB_BYPASS_EN to forward a same-cycle writeback into captured operands.
module decode_pipe_stage #(
  parameter int         DATA_W      = 16,
  parameter int         REG_COUNT   = 16,
  parameter logic [3:0] LOAD_OPCODE = 4'hA
) (
  input logic                clock,
  input logic                reset_n,
  decode_pipe_stage_if.slave bus
);
  localparam int RID_W = $clog2(REG_COUNT);
  typedef logic [RID_W-1:0] rid_t;

  function automatic rid_t field_id(input logic [3:0] f);
    return rid_t'(f);
  endfunction

  function automatic logic signed [DATA_W-1:0] sext_imm(input logic [3:0] f);
    return {{(DATA_W-4){f[3]}}, f};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic signed [DATA_W-1:0] rf [REG_COUNT];

  logic                     vld_p1;
  logic [3:0]               opcode_p1;
  logic                     is_load_p1;
  rid_t                     rs_id_p1, rt_id_p1, rd_id_p1;
  logic signed [DATA_W-1:0] rs_val_p1, rt_val_p1, imm_p1;
  logic [DATA_W-1:0]        pc_p1;
  logic [15:0]              stall_cnt;

  rid_t                     rs_id, rt_id, rd_id;
  logic signed [DATA_W-1:0] rs_cap, rt_cap;
  logic                     wb_hit, hazard, in_ready, accept;

  assign rs_id  = field_id(bus.instruction[11:8]);
  assign rt_id  = field_id(bus.instruction[7:4]);
  assign rd_id  = field_id(bus.instruction[3:0]);
  assign wb_hit = bus.wb_en && (bus.wb_id != '0);

  // A load still in the output register whose target feeds the incoming instruction.
  assign hazard = vld_p1 && is_load_p1 && (rd_id_p1 != '0) && bus.in_valid &&
                  ((rd_id_p1 == rs_id) || (rd_id_p1 == rt_id));
  assign in_ready = reset_n && (bus.flush || ((!vld_p1 || bus.out_ready) && !hazard));
  assign accept   = bus.in_valid && in_ready && !bus.flush;

  always_comb begin
    rs_cap = (rs_id == '0) ? '0 : rf[rs_id];
    rt_cap = (rt_id == '0) ? '0 : rf[rt_id];
`ifdef DECODE_WB_BYPASS_EN
    if (wb_hit && (bus.wb_id == rs_id)) rs_cap = bus.wb_value;
    if (wb_hit && (bus.wb_id == rt_id)) rt_cap = bus.wb_value;
`endif
  end

  // ---- stage p0 -> p1 ----
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vld_p1     <= 1'b0;
      opcode_p1  <= '0;
      is_load_p1 <= 1'b0;
      rs_id_p1   <= '0;
      rt_id_p1   <= '0;
      rd_id_p1   <= '0;
      rs_val_p1  <= '0;
      rt_val_p1  <= '0;
      imm_p1     <= '0;
      pc_p1      <= '0;
      stall_cnt  <= '0;
      for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
    end else begin
      if (wb_hit) rf[bus.wb_id] <= bus.wb_value;

      if (bus.flush) begin
        vld_p1 <= 1'b0;
      end else if (vld_p1 && !bus.out_ready) begin
        // Held operands must not go stale while execute is back-pressuring.
        if (wb_hit && (bus.wb_id == rs_id_p1)) rs_val_p1 <= bus.wb_value;
        if (wb_hit && (bus.wb_id == rt_id_p1)) rt_val_p1 <= bus.wb_value;
      end else begin
        vld_p1 <= accept;
        if (accept) begin
          opcode_p1  <= bus.instruction[15:12];
          is_load_p1 <= (bus.instruction[15:12] == LOAD_OPCODE);
          rs_id_p1   <= rs_id;
          rt_id_p1   <= rt_id;
          rd_id_p1   <= rd_id;
          rs_val_p1  <= rs_cap;
          rt_val_p1  <= rt_cap;
          imm_p1     <= sext_imm(bus.instruction[3:0]);
          pc_p1      <= bus.pc_plus_two;
        end
      end

      if (bus.in_valid && !in_ready && !bus.flush) stall_cnt <= sat_inc16(stall_cnt);
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = vld_p1;
  assign bus.out_opcode      = opcode_p1;
  assign bus.out_is_load     = is_load_p1;
  assign bus.out_rs_id       = rs_id_p1;
  assign bus.out_rt_id       = rt_id_p1;
  assign bus.out_rd_id       = rd_id_p1;
  assign bus.out_rs_value    = rs_val_p1;
  assign bus.out_rt_value    = rt_val_p1;
  assign bus.out_imm         = imm_p1;
  assign bus.out_pc_plus_two = pc_p1;
  assign bus.stall_cycles    = stall_cnt;
endmodule

// File: doc/decode_pipe_stage.md
DECODE_PIPE_STAGE -- requirements
Module: decode_pipe_stage

Interface
REQ-001 Parameter DATA_W, default 16, operand/PC/writeback data width (>=8).
REQ-002 Parameter REG_COUNT, default 16, architectural registers; id width RID_W = clog2(REG_COUNT), 4 at default.
REQ-003 Parameter LOAD_OPCODE, default 4'hA, opcode value marking a load.
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 in_valid / in_ready  in / out  1 / 1  fetch-side handshake.
REQ-007 instruction  in  16  fields: opcode[15:12], rs[11:8], rt[7:4], rd[3:0]; imm = instr[3:0] sign-extended to DATA_W.
REQ-008 pc_plus_two  in  DATA_W  PC of the next instruction.
REQ-009 wb_en, wb_id, wb_value  in  1, RID_W, DATA_W  writeback port.
REQ-010 flush  in  1  squash the held and incoming instruction.
REQ-011 out_valid / out_ready  out / in  1 / 1  execute-side handshake.
REQ-012 out_rs_value, out_rt_value, out_imm, out_pc_plus_two  out  DATA_W  registered payload.
REQ-013 out_rs_id, out_rt_id, out_rd_id  out  RID_W; out_opcode  out  4; out_is_load  out  1 (opcode==LOAD_OPCODE).
REQ-014 stall_cycles  out  16  saturating count of fetch-stall cycles.

Function
REQ-015 Register file REG_COUNT x DATA_W; register 0 reads 0, writes to id 0 ignored.
REQ-016 Write at clock edge when wb_en=1 and wb_id!=0.
REQ-017 hazard = out_valid & out_is_load & out_rd_id!=0 & in_valid & (out_rd_id==rs | out_rd_id==rt).
REQ-018 in_ready = reset_n & (flush | ((!out_valid | out_ready) & !hazard)), combinational.
REQ-019 Edge priority: flush -> out_valid<=0, incoming instruction discarded; else if out_valid & !out_ready -> payload held; else out_valid<=in_valid & !hazard, payload captured on accept.
REQ-020 Accept-to-out_valid latency exactly 1 cycle; throughput 1 instruction/cycle without hazard or backpressure.
REQ-021 Load-use hazard inserts exactly one bubble: load advances, dependent instruction accepted the following cycle.
REQ-022 While payload held, a writeback to nonzero out_rs_id/out_rt_id updates out_rs_value/out_rt_value at that edge.
REQ-023 stall_cycles increments each cycle with in_valid & !in_ready & !flush; saturates at 16'hFFFF, no wrap.
REQ-024 flush simultaneous with out_ready=0: flush wins, held instruction dropped.

Reset
REQ-025 reset_n=0 at an edge: out_valid, all payload outputs, all registers, stall_cycles -> 0; in_ready=0 while reset_n=0.
REQ-026 Reset mid-stall or mid-hold discards all in-flight state; writeback ignored during reset edge.

Configuration
REQ-027 Macro DECODE_WB_BYPASS_EN defined: on capture, operand whose id equals wb_id (nonzero, wb_en=1) takes wb_value same cycle.
REQ-028 Macro undefined: capture reads pre-write register value; the write lands at the same edge, no bypass.

Verification
REQ-029 Reset, write r3=16'h1234 via wb, issue rs=3 -> one cycle later out_valid=1, out_rs_value=16'h1234.
REQ-030 Load rd=5 then add rs=5 back-to-back -> in_ready=0 one cycle, one bubble, stall_cycles=1.
REQ-031 out_ready=0 for 4 cycles with in_valid=1 -> payload stable, stall_cycles=4; wb r(out_rt_id)=16'hBEEF during hold -> out_rt_value=16'hBEEF.
REQ-032 wb r7=16'h00FF same cycle as capture rs=7 -> out_rs_value=16'h00FF with macro, old value without.
REQ-033 flush with out_valid=1, out_ready=0 -> next cycle out_valid=0, incoming dropped; wb id 0 value 16'hFFFF -> r0 reads 0.
REQ-034 Hold in_valid=1, out_ready=0 for 70000 cycles -> stall_cycles=16'hFFFF, stays.
